mux_rr_reg: RTL and testbench

MUX_RR_REG -- requirements
Module: mux_rr_reg

---
 rtl/mux_rr_reg.sv | 97 +++++++++
 tb/tb_mux_rr_reg.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_reg.sv
// Registered NCH:1 channel multiplexer with manual or round-robin selection and a valid/ready output stage.
// Defining MUX_RR_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module mux_rr_reg #(
  parameter int WIDTH = 6,
  parameter int NCH   = 4,
  parameter int SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     out_ch
`ifdef MUX_RR_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  logic [SEL_W-1:0] ptr;
  logic             load;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_found;
  logic [SEL_W-1:0] pick;
  logic             pick_valid;
  logic [WIDTH-1:0] pick_data;

  assign load = ~out_valid | out_ready;

  // Search starts at ptr; SEL_W-bit addition wraps naturally because NCH == 2**SEL_W.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment, so no latch is inferred.
    idx      = ptr;
    rr_found = 1'b0;
    rr_grant = ptr;
    for (int k = 0; k < NCH; k++) begin
      idx = ptr + SEL_W'(k);
      if (!rr_found && in_valid[idx]) begin
        rr_found = 1'b1;
        rr_grant = idx;
      end
    end
  end

  always_comb begin
    pick       = mode ? rr_grant : sel;
    pick_valid = mode ? rr_found : in_valid[sel];
    pick_data  = in[int'(pick)*WIDTH +: WIDTH];
  end

  always_comb begin
    in_ready = '0;
    if (!rst && load && pick_valid)
      in_ready[pick] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (mode) begin
        if (rr_found) begin
          out       <= pick_data;
          out_valid <= 1'b1;
          out_ch    <= rr_grant;
          ptr       <= rr_grant + SEL_W'(1);
        end else begin
          out_valid <= 1'b0;
        end
      end else begin
        out       <= pick_data;
        out_valid <= in_valid[sel];
        out_ch    <= sel;
      end
    end
  end

`ifdef MUX_RR_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mux_rr_reg.sv
// Self-checking bench for mux_rr_reg: a cycle model pushes expected output words to a scoreboard,
// popped and compared one cycle later; scenario tasks add directed checks.
module tb_mux_rr_reg;
  localparam int WIDTH = 6;
  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH*WIDTH-1:0] in;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [SEL_W-1:0]     sel;
  logic                 mode;
  logic [WIDTH-1:0]     out;
  logic                 out_valid;
  logic                 out_ready;
  logic [SEL_W-1:0]     out_ch;
`ifdef MUX_RR_STALL_CNT_EN
  logic [15:0]          stall_cnt;
`endif

  mux_rr_reg #(.WIDTH(WIDTH), .NCH(NCH), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
`ifdef MUX_RR_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             valid;
    logic [SEL_W-1:0] ch;
    logic [15:0]      stall;
  } exp_t;

  logic [WIDTH-1:0] chd [NCH];
  exp_t             sb [$];
  exp_t             m_out = '0;
  logic [SEL_W-1:0] m_ptr = '0;
  logic [NCH-1:0]   obs_in_ready;
  int               compared = 0;
  int               mismatched = 0;

  always_comb begin
    in = '0;
    for (int i = 0; i < NCH; i++) in[i*WIDTH +: WIDTH] = chd[i];
  end

  function automatic int rr_pick(input int p, input logic [NCH-1:0] v);
    for (int k = 0; k < NCH; k++)
      if (v[(p + k) % NCH]) return (p + k) % NCH;
    return -1;
  endfunction

  // Called with inputs already set just after a falling edge; returns at the next falling edge.
  task automatic step(input string tag);
    exp_t           e;
    logic           load;
    logic [NCH-1:0] exp_rdy;
    int             g;
    #1;
    load    = !m_out.valid || out_ready;
    exp_rdy = '0;
    g       = -1;
    if (!rst && load) begin
      if (mode) g = rr_pick(int'(m_ptr), in_valid);
      else if (in_valid[sel]) g = int'(sel);
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    obs_in_ready = in_ready;
    compared++;
    if (in_ready !== exp_rdy) begin
      mismatched++;
      $display("FAIL %s in_ready: got %b expected %b", tag, in_ready, exp_rdy);
    end
    if (rst) begin
      m_out = '0;
      m_ptr = '0;
    end else begin
      if (m_out.valid && !out_ready && m_out.stall != 16'hFFFF) m_out.stall = m_out.stall + 16'd1;
      if (load) begin
        if (mode) begin
          if (g >= 0) begin
            m_out.data  = chd[g];
            m_out.valid = 1'b1;
            m_out.ch    = SEL_W'(g);
            m_ptr       = SEL_W'((g + 1) % NCH);
          end else begin
            m_out.valid = 1'b0;
          end
        end else begin
          m_out.data  = chd[sel];
          m_out.valid = in_valid[sel];
          m_out.ch    = sel;
        end
      end
    end
    sb.push_back(m_out);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      compared++;
      if (out !== e.data || out_valid !== e.valid || out_ch !== e.ch) begin
        mismatched++;
        $display("FAIL %s out/valid/ch: got %h/%b/%0d expected %h/%b/%0d",
                 tag, out, out_valid, out_ch, e.data, e.valid, e.ch);
      end
`ifdef MUX_RR_STALL_CNT_EN
      compared++;
      if (stall_cnt !== e.stall) begin
        mismatched++;
        $display("FAIL %s stall_cnt: got %0d expected %0d", tag, stall_cnt, e.stall);
      end
`endif
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; sel = 2'd2; in_valid = '1; out_ready = 1'b1;
    for (int i = 0; i < NCH; i++) chd[i] = WIDTH'(i + 7);
    step("reset0");
    step("reset1");
    compared++;
    if (obs_in_ready !== 4'b0000 || out !== 6'h00 || out_valid !== 1'b0 || out_ch !== 2'd0) begin
      mismatched++;
      $display("FAIL reset_state: got rdy=%b out=%h v=%b ch=%0d expected 0000/00/0/0",
               obs_in_ready, out, out_valid, out_ch);
    end
    rst = 1'b0;
  endtask

  task automatic test_manual();
    mode = 1'b0; sel = 2'd2; out_ready = 1'b1; in_valid = 4'b0100;
    for (int i = 0; i < NCH; i++) chd[i] = WIDTH'($urandom);
    chd[2] = 6'h2A;
    step("manual_sel2");
    compared++;
    if (obs_in_ready !== 4'b0100 || out !== 6'h2A || out_valid !== 1'b1 || out_ch !== 2'd2) begin
      mismatched++;
      $display("FAIL manual_sel2: got rdy=%b out=%h v=%b ch=%0d expected 0100/2a/1/2",
               obs_in_ready, out, out_valid, out_ch);
    end
    sel = 2'd1;
    step("manual_invalid");
    compared++;
    if (obs_in_ready !== 4'b0000 || out_valid !== 1'b0 || out_ch !== 2'd1) begin
      mismatched++;
      $display("FAIL manual_invalid: got rdy=%b v=%b ch=%0d expected 0000/0/1", obs_in_ready, out_valid, out_ch);
    end
  endtask

  task automatic test_rr_sequence();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < NCH; c++) chd[c] = WIDTH'($urandom);
      step("rr_seq");
      compared++;
      if (int'(out_ch) != exp_seq[i] || out_valid !== 1'b1) begin
        mismatched++;
        $display("FAIL rr_seq[%0d]: got ch=%0d v=%b expected ch=%0d v=1", i, out_ch, out_valid, exp_seq[i]);
      end
    end
  endtask

  task automatic test_rr_skip();
    in_valid = 4'b0100;
    step("rr_to_ptr3");
    in_valid = 4'b0101;
    step("rr_wrap_ch0");
    compared++;
    if (out_ch !== 2'd0) begin
      mismatched++;
      $display("FAIL rr_wrap_ch0: got ch=%0d expected 0", out_ch);
    end
    step("rr_next_ch2");
    compared++;
    if (out_ch !== 2'd2) begin
      mismatched++;
      $display("FAIL rr_next_ch2: got ch=%0d expected 2", out_ch);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0; in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < NCH; c++) chd[c] = WIDTH'($urandom);
      step("stall");
      compared++;
      if (obs_in_ready !== 4'b0000 || out_ch !== 2'd2 || out_valid !== 1'b1) begin
        mismatched++;
        $display("FAIL stall[%0d]: got rdy=%b ch=%0d v=%b expected 0000/2/1", i, obs_in_ready, out_ch, out_valid);
      end
    end
`ifdef MUX_RR_STALL_CNT_EN
    compared++;
    if (stall_cnt !== 16'd3) begin
      mismatched++;
      $display("FAIL stall_cnt3: got %0d expected 3", stall_cnt);
    end
`endif
    out_ready = 1'b1;
    step("stall_release");
    compared++;
    if (out_ch !== 2'd3) begin
      mismatched++;
      $display("FAIL stall_release: got ch=%0d expected 3", out_ch);
    end
  endtask

  task automatic test_idle();
    logic [WIDTH-1:0] held;
    in_valid = 4'b0010; chd[1] = 6'h33;
    step("idle_pre");
    held = chd[1];
    in_valid = 4'b0000; chd[1] = 6'h0C;
    step("idle");
    compared++;
    if (out_valid !== 1'b0 || out !== held || out_ch !== 2'd1) begin
      mismatched++;
      $display("FAIL idle: got v=%b out=%h ch=%0d expected 0/%h/1", out_valid, out, out_ch, held);
    end
    in_valid = 4'b1111;
    step("idle_after");
    compared++;
    if (out_ch !== 2'd2) begin
      mismatched++;
      $display("FAIL idle_after: got ch=%0d expected 2", out_ch);
    end
  endtask

  task automatic test_reset_mid();
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; chd[1] = 6'h15; out_ready = 1'b1;
    step("pre_reset");
    rst = 1'b1; out_ready = 1'b0; mode = 1'b1; in_valid = 4'b1111;
    step("mid_reset");
    compared++;
    if (out !== 6'h00 || out_valid !== 1'b0 || out_ch !== 2'd0 || obs_in_ready !== 4'b0000) begin
      mismatched++;
      $display("FAIL mid_reset: got out=%h v=%b ch=%0d rdy=%b expected 00/0/0/0000",
               out, out_valid, out_ch, obs_in_ready);
    end
    rst = 1'b0; out_ready = 1'b1;
    step("post_reset");
    compared++;
    if (out_ch !== 2'd0 || out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL post_reset: got ch=%0d v=%b expected 0/1", out_ch, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 80; i++) begin
      rst       = ($urandom_range(0, 29) == 0);
      mode      = ($urandom_range(0, 3) != 0);
      sel       = SEL_W'($urandom);
      in_valid  = NCH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NCH; c++) chd[c] = WIDTH'($urandom);
      step("random");
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b1;
    for (int i = 0; i < NCH; i++) chd[i] = '0;
    @(negedge clk);
    test_reset();
    test_manual();
    test_rr_sequence();
    test_rr_skip();
    test_stall();
    test_idle();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
